// File: rtl/sc_level_sequencer_pkg.sv
// Shared definitions for the level sequencer: state encoding, decoder codes and defaults.
package sc_level_sequencer_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_LOAD_BANNER = 3'd1;
  localparam logic [2:0] ST_SHOW_BANNER = 3'd2;
  localparam logic [2:0] ST_LOAD_PLAY   = 3'd3;
  localparam logic [2:0] ST_PLAY        = 3'd4;
  localparam logic [2:0] ST_DONE        = 3'd5;

  typedef enum logic [2:0] {
    StIdle       = ST_IDLE,
    StLoadBanner = ST_LOAD_BANNER,
    StShowBanner = ST_SHOW_BANNER,
    StLoadPlay   = ST_LOAD_PLAY,
    StPlay       = ST_PLAY,
    StDone       = ST_DONE
  } seq_state_e;

  // Decoder code for the play field; 1..LEVEL_MAX select the level banners.
  localparam logic [2:0] TRANS_PLAY = 3'b000;

  // Must match the number of banner bitmaps the decoder provides.
  localparam int unsigned LEVEL_MAX_DEFAULT   = 4;
  localparam int unsigned SHOW_CYCLES_DEFAULT = 50_000_000;
  localparam int unsigned CNT_W_DEFAULT       = 26;

  function automatic logic is_load_state(seq_state_e s);
    return (s == StLoadBanner) || (s == StLoadPlay);
  endfunction

  function automatic logic is_banner_state(seq_state_e s);
    return (s == StLoadBanner) || (s == StShowBanner);
  endfunction

endpackage

// File: rtl/sc_level_sequencer_if.sv
// Game-logic side signals of the level sequencer, with sequencer (slave) and driver (master) views.
interface sc_level_sequencer_if;

  logic       SC_LEVELSEQ_start_InLow;
  logic       SC_LEVELSEQ_levelDone_InLow;
  logic       SC_LEVELSEQ_gameOver_InLow;
  logic [2:0] SC_LEVELSEQ_transition_OutBUS;
  logic       SC_LEVELSEQ_load_OutLow;
  logic [2:0] SC_LEVELSEQ_level_OutBUS;
  logic       SC_LEVELSEQ_playing_Out;
  logic       SC_LEVELSEQ_win_Out;

  modport master (
    output SC_LEVELSEQ_start_InLow,
    output SC_LEVELSEQ_levelDone_InLow,
    output SC_LEVELSEQ_gameOver_InLow,
    input  SC_LEVELSEQ_transition_OutBUS,
    input  SC_LEVELSEQ_load_OutLow,
    input  SC_LEVELSEQ_level_OutBUS,
    input  SC_LEVELSEQ_playing_Out,
    input  SC_LEVELSEQ_win_Out
  );

  modport slave (
    input  SC_LEVELSEQ_start_InLow,
    input  SC_LEVELSEQ_levelDone_InLow,
    input  SC_LEVELSEQ_gameOver_InLow,
    output SC_LEVELSEQ_transition_OutBUS,
    output SC_LEVELSEQ_load_OutLow,
    output SC_LEVELSEQ_level_OutBUS,
    output SC_LEVELSEQ_playing_Out,
    output SC_LEVELSEQ_win_Out
  );

endinterface

// File: rtl/sc_banner_timer.sv
// Banner hold counter: synchronous clear, count enable, terminal-count flag at SHOW_CYCLES-1.
module sc_banner_timer #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned SHOW_CYCLES = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TcValue = CNT_W'(SHOW_CYCLES - 1);

  logic [CNT_W-1:0] r_count_q;
  logic [CNT_W-1:0] w_count_d;

  always_comb begin
    w_count_d = r_count_q;
    if (i_clr) begin
      w_count_d = '0;
    end else if (i_en) begin
      w_count_d = r_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count_q <= '0;
    end else begin
      r_count_q <= w_count_d;
    end
  end

  assign o_tc = (r_count_q == TcValue);

endmodule

// File: rtl/sc_level_sequencer.sv
// Level sequencer: banner per level, then play field; one-cycle load strobes for the bitmap regs.
module sc_level_sequencer
  import sc_level_sequencer_pkg::*;
#(
  parameter int unsigned LEVEL_MAX   = LEVEL_MAX_DEFAULT,
  parameter int unsigned SHOW_CYCLES = SHOW_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic                 SC_LEVELSEQ_CLOCK_50,
  input  logic                 SC_LEVELSEQ_RESET_InHigh,
  sc_level_sequencer_if.slave  seq
);

  localparam logic [2:0] LevelMax = 3'(LEVEL_MAX);
  localparam logic [2:0] LevelOne = 3'd1;

  seq_state_e r_state_q, w_state_d;
  logic [2:0] r_level_q, w_level_d;
  logic [2:0] r_trans_q, w_trans_d;
  logic       r_load_n_q, w_load_n_d;
  logic       r_playing_q, w_playing_d;
  logic       r_win_q, w_win_d;

  logic w_timer_clr;
  logic w_timer_en;
  logic w_timer_tc;

  sc_banner_timer #(
    .CNT_W       (CNT_W),
    .SHOW_CYCLES (SHOW_CYCLES)
  ) u_banner_timer (
    .i_clk (SC_LEVELSEQ_CLOCK_50),
    .i_rst (SC_LEVELSEQ_RESET_InHigh),
    .i_clr (w_timer_clr),
    .i_en  (w_timer_en),
    .o_tc  (w_timer_tc)
  );

  assign w_timer_clr = (r_state_q == StLoadBanner);
  assign w_timer_en  = (r_state_q == StShowBanner);

  always_comb begin
    w_state_d = r_state_q;
    w_level_d = r_level_q;
    case (r_state_q)
      StIdle: begin
        if (!seq.SC_LEVELSEQ_start_InLow) begin
          w_level_d = LevelOne;
          w_state_d = StLoadBanner;
        end
      end
      StLoadBanner: w_state_d = StShowBanner;
      StShowBanner: begin
        if (w_timer_tc) begin
          w_state_d = StLoadPlay;
        end
      end
      StLoadPlay: w_state_d = StPlay;
      StPlay: begin
        // A loss outranks a simultaneous completion: the level restarts.
        if (!seq.SC_LEVELSEQ_gameOver_InLow) begin
          w_state_d = StLoadBanner;
        end else if (!seq.SC_LEVELSEQ_levelDone_InLow) begin
          if (r_level_q < LevelMax) begin
            w_level_d = r_level_q + 3'd1;
            w_state_d = StLoadBanner;
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!seq.SC_LEVELSEQ_start_InLow) begin
          w_level_d = LevelOne;
          w_state_d = StLoadBanner;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Outputs are derived from the next state so they register on the same edge as the state.
    w_trans_d   = is_banner_state(w_state_d) ? w_level_d : TRANS_PLAY;
    w_load_n_d  = !is_load_state(w_state_d);
    w_playing_d = (w_state_d == StPlay);
    w_win_d     = (w_state_d == StDone);
  end

  always_ff @(posedge SC_LEVELSEQ_CLOCK_50 or posedge SC_LEVELSEQ_RESET_InHigh) begin
    if (SC_LEVELSEQ_RESET_InHigh) begin
      r_state_q   <= StIdle;
      r_level_q   <= LevelOne;
      r_trans_q   <= TRANS_PLAY;
      r_load_n_q  <= 1'b1;
      r_playing_q <= 1'b0;
      r_win_q     <= 1'b0;
    end else begin
      r_state_q   <= w_state_d;
      r_level_q   <= w_level_d;
      r_trans_q   <= w_trans_d;
      r_load_n_q  <= w_load_n_d;
      r_playing_q <= w_playing_d;
      r_win_q     <= w_win_d;
    end
  end

  assign seq.SC_LEVELSEQ_transition_OutBUS = r_trans_q;
  assign seq.SC_LEVELSEQ_load_OutLow       = r_load_n_q;
  assign seq.SC_LEVELSEQ_level_OutBUS      = r_level_q;
  assign seq.SC_LEVELSEQ_playing_Out       = r_playing_q;
  assign seq.SC_LEVELSEQ_win_Out           = r_win_q;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Bench for sc_level_sequencer: directed scenarios plus random play against a timeline model.
module tb_sc_level_sequencer;

  localparam int unsigned SHOW = 4;
  localparam int unsigned LMAX = 4;
  localparam int unsigned CW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic st_n, ld_n, go_n;

  always #5 clk = ~clk;

  sc_level_sequencer_if seq ();

  sc_level_sequencer #(
    .LEVEL_MAX   (LMAX),
    .SHOW_CYCLES (SHOW),
    .CNT_W       (CW)
  ) dut (
    .SC_LEVELSEQ_CLOCK_50     (clk),
    .SC_LEVELSEQ_RESET_InHigh (rst),
    .seq                      (seq)
  );

  assign seq.SC_LEVELSEQ_start_InLow     = st_n;
  assign seq.SC_LEVELSEQ_levelDone_InLow = ld_n;
  assign seq.SC_LEVELSEQ_gameOver_InLow  = go_n;

  logic [2:0] trans, level;
  logic       load_n, playing, win;
  logic [8:0] dut_vec;
  assign trans   = seq.SC_LEVELSEQ_transition_OutBUS;
  assign load_n  = seq.SC_LEVELSEQ_load_OutLow;
  assign level   = seq.SC_LEVELSEQ_level_OutBUS;
  assign playing = seq.SC_LEVELSEQ_playing_Out;
  assign win     = seq.SC_LEVELSEQ_win_Out;
  assign dut_vec = {trans, load_n, level, playing, win};

  localparam logic [8:0] ResetVec = {3'b000, 1'b1, 3'd1, 1'b0, 1'b0};

  int n_tests = 0;
  int n_fail  = 0;

  // Timeline model: phase 0 idle, 1 banner (age counts cycles since strobe), 2 play strobe,
  // 3 play, 4 won.
  int m_phase, m_level, m_age;

  function automatic void model_reset();
    m_phase = 0;
    m_level = 1;
    m_age   = 0;
  endfunction

  function automatic void new_banner();
    m_phase = 1;
    m_age   = 0;
  endfunction

  function automatic void model_step();
    case (m_phase)
      0: if (!st_n) begin m_level = 1; new_banner(); end
      1: if (m_age == int'(SHOW)) m_phase = 2; else m_age++;
      2: m_phase = 3;
      3: begin
        if (!go_n) new_banner();
        else if (!ld_n) begin
          if (m_level < int'(LMAX)) begin m_level++; new_banner(); end
          else m_phase = 4;
        end
      end
      4: if (!st_n) begin m_level = 1; new_banner(); end
      default: m_phase = 0;
    endcase
  endfunction

  function automatic logic [8:0] exp_vec();
    logic [2:0] t;
    logic       ld;
    t  = (m_phase == 1) ? 3'(m_level) : 3'b000;
    ld = !((m_phase == 1 && m_age == 0) || m_phase == 2);
    return {t, ld, 3'(m_level), m_phase == 3, m_phase == 4};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  // Advances through a banner that is showing now; stops at the first non-banner cycle.
  task automatic watch_banner(output int cycles, output int strobes, output int mism);
    cycles = 0; strobes = 0; mism = 0;
    for (int i = 0; i < 30; i++) begin
      if (trans == 3'b000) break;
      cycles++;
      if (!load_n) strobes++;
      if (dut_vec !== exp_vec()) mism++;
      tick();
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (dut_vec !== ResetVec) begin
      n_fail++; $display("FAIL reset_async: got %b want %b", dut_vec, ResetVec);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (dut_vec !== ResetVec) begin
      n_fail++; $display("FAIL reset_idle_hold: got %b want %b", dut_vec, ResetVec);
    end
  endtask

  task automatic test_start_banner();
    int b, s, m;
    st_n = 1'b0; tick(); st_n = 1'b1;
    n_tests++;
    if ({trans, load_n} !== {3'b001, 1'b0}) begin
      n_fail++; $display("FAIL start_strobe: got %b want %b", {trans, load_n}, 4'b0010);
    end
    watch_banner(b, s, m);
    n_tests++;
    if (b != 5) begin n_fail++; $display("FAIL start_banner_len: got %0d want 5", b); end
    n_tests++;
    if (s != 1 || m != 0) begin
      n_fail++; $display("FAIL start_banner_trace: strobes %0d mism %0d want 1 0", s, m);
    end
    n_tests++;
    if ({trans, load_n, playing} !== 5'b00000) begin
      n_fail++; $display("FAIL start_play_strobe: got %b want 00000", {trans, load_n, playing});
    end
    tick();
    n_tests++;
    if ({playing, load_n} !== 2'b11 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL start_playing: got %b want %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_ignore_in_banner();
    int b, s, m;
    go_n = 1'b0; tick();               // restart level 1 from PLAY
    go_n = 1'b1;
    st_n = 1'b0; ld_n = 1'b0; go_n = 1'b0;
    watch_banner(b, s, m);
    st_n = 1'b1; ld_n = 1'b1; go_n = 1'b1;
    n_tests++;
    if (b != 5 || s != 1 || m != 0 || level !== 3'd1) begin
      n_fail++;
      $display("FAIL ignore_banner: len %0d strobes %0d mism %0d level %0d want 5 1 0 1",
               b, s, m, level);
    end
    tick();
    n_tests++;
    if ({playing, level} !== {1'b1, 3'd1}) begin
      n_fail++; $display("FAIL ignore_play: got %b want 1001", {playing, level});
    end
  endtask

  task automatic test_level_advance();
    int b, s, m;
    ld_n = 1'b0; tick(); ld_n = 1'b1;  // level 1 -> 2
    watch_banner(b, s, m); tick();
    ld_n = 1'b0; tick(); ld_n = 1'b1;  // level 2 -> 3
    n_tests++;
    if ({level, trans, load_n} !== {3'd3, 3'b011, 1'b0}) begin
      n_fail++; $display("FAIL advance_lvl3: got %b want 0110110", {level, trans, load_n});
    end
    watch_banner(b, s, m);
    n_tests++;
    if (b != 5 || s != 1 || m != 0) begin
      n_fail++; $display("FAIL advance_banner: len %0d strobes %0d mism %0d want 5 1 0", b, s, m);
    end
    tick();
  endtask

  task automatic test_both_events();
    int b, s, m;
    ld_n = 1'b0; go_n = 1'b0; tick(); ld_n = 1'b1; go_n = 1'b1;
    n_tests++;
    if ({level, trans, load_n} !== {3'd3, 3'b011, 1'b0}) begin
      n_fail++; $display("FAIL both_restart: got %b want 0110110", {level, trans, load_n});
    end
    watch_banner(b, s, m); tick();
    n_tests++;
    if (m != 0 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL both_replay: got %b want %b mism %0d", dut_vec, exp_vec(), m);
    end
  endtask

  task automatic test_done();
    int b, s, m;
    int strobes;
    ld_n = 1'b0; tick(); ld_n = 1'b1;  // level 3 -> 4
    watch_banner(b, s, m); tick();
    ld_n = 1'b0; tick(); ld_n = 1'b1;  // level 4 -> DONE
    n_tests++;
    if ({win, playing, trans, load_n} !== {1'b1, 1'b0, 3'b000, 1'b1}) begin
      n_fail++; $display("FAIL done_enter: got %b want 100001", {win, playing, trans, load_n});
    end
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      ld_n = i[0]; go_n = 1'b0; tick();
      if (!load_n || !win) strobes++;
    end
    ld_n = 1'b1; go_n = 1'b1;
    n_tests++;
    if (strobes != 0) begin
      n_fail++; $display("FAIL done_hold: got %0d strobes/drops want 0", strobes);
    end
    st_n = 1'b0; tick(); st_n = 1'b1;
    n_tests++;
    if ({level, trans, load_n, win} !== {3'd1, 3'b001, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL done_restart: got %b want 00100100", {level, trans, load_n, win});
    end
  endtask

  task automatic test_reset_mid_banner();
    int strobes;
    tick(); tick();                    // inside SHOW_BANNER of level 1
    #3 rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (dut_vec !== ResetVec) begin
      n_fail++; $display("FAIL reset_mid_banner: got %b want %b", dut_vec, ResetVec);
    end
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!load_n) strobes++;
    end
    #3 rst = 1'b0;
    tick();
    n_tests++;
    if (strobes != 0 || dut_vec !== ResetVec) begin
      n_fail++; $display("FAIL reset_no_strobe: got %b strobes %0d want %b 0", dut_vec, strobes,
                         ResetVec);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      st_n = ($urandom_range(7) != 0);
      ld_n = ($urandom_range(5) != 0);
      go_n = ($urandom_range(9) != 0);
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        if (bad < 10) $display("FAIL random_cycle_%0d: got %b want %b", i, dut_vec, exp_vec());
        bad++;
      end
    end
    st_n = 1'b1; ld_n = 1'b1; go_n = 1'b1;
  endtask

  initial begin
    st_n = 1'b1; ld_n = 1'b1; go_n = 1'b1;
    model_reset();
    test_reset();
    test_start_banner();
    test_ignore_in_banner();
    test_level_advance();
    test_both_events();
    test_done();
    test_reset_mid_banner();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
